// File: rtl/q_frag_ff_arbiter.sv
// Round-robin arbiter sharing one Q_FRAG flip-flop bank between the internal
// CZI path (INT) and the external QDI path (EXT), with bounded burst grants.
module q_frag_ff_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             QST,
    input  logic             QEN,
    input  logic             INT_REQ,
    input  logic [WIDTH-1:0] INT_DAT,
    input  logic             INT_LAST,
    output logic             INT_ACK,
    input  logic             EXT_REQ,
    input  logic [WIDTH-1:0] EXT_DAT,
    input  logic             EXT_LAST,
    output logic             EXT_ACK,
    output logic [WIDTH-1:0] QZ,
    output logic             QZ_VLD,
    output logic             MODE_EXT,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G_INT = 2'd1,
        G_EXT = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t           r_state;
    state_t           w_nextState;
    logic [3:0]       r_cnt;
    logic [3:0]       w_nextCnt;
    logic [3:0]       w_cntInc;
    logic             r_lastSrv;
    logic             w_nextLastSrv;
    logic [WIDTH-1:0] r_qz;
    logic             r_qzVld;
    logic             r_modeExt;

    logic             w_curIsExt;
    logic             w_curReq;
    logic             w_curLast;
    logic             w_othReq;
    logic             w_xfer;
    logic             w_burstEnd;
    logic             w_restart;

    // ACK is withheld while set or reset is applied so no beat is lost to them
    assign INT_ACK  = (r_state == G_INT) & INT_REQ & QEN & ~QST & ~QRT;
    assign EXT_ACK  = (r_state == G_EXT) & EXT_REQ & QEN & ~QST & ~QRT;
    assign w_xfer   = INT_ACK | EXT_ACK;

    assign w_curIsExt = (r_state == G_EXT);
    assign w_curReq   = w_curIsExt ? EXT_REQ  : INT_REQ;
    assign w_curLast  = w_curIsExt ? EXT_LAST : INT_LAST;
    assign w_othReq   = w_curIsExt ? INT_REQ  : EXT_REQ;
    assign w_cntInc   = r_cnt + 4'd1;

    assign QZ       = r_qz;
    assign QZ_VLD   = r_qzVld;
    assign MODE_EXT = r_modeExt;
    assign BUSY     = (r_state != IDLE);

    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = r_cnt;
        w_nextLastSrv = r_lastSrv;
        w_burstEnd    = 1'b0;
        w_restart     = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextCnt = 4'd0;
                // r_lastSrv=1 means EXT was served last, so INT wins a tie
                if (INT_REQ && (!EXT_REQ || r_lastSrv))
                    w_nextState = G_INT;
                else if (EXT_REQ)
                    w_nextState = G_EXT;
            end
            G_INT, G_EXT: begin
                if (w_xfer) begin
                    if (w_curLast || (w_cntInc == MAX_B)) begin
                        w_burstEnd = 1'b1;
                        w_restart  = ~w_curLast & w_curReq;
                    end else begin
                        w_nextCnt = w_cntInc;
                    end
                end else begin
                    w_burstEnd = 1'b1;
                end
                if (w_burstEnd) begin
                    w_nextLastSrv = w_curIsExt;
                    w_nextCnt     = 4'd0;
                    if (w_othReq)
                        w_nextState = w_curIsExt ? G_INT : G_EXT;
                    else if (w_restart)
                        w_nextState = r_state;
                    else
                        w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_lastSrv <= 1'b1;
            r_qz      <= '0;
            r_qzVld   <= 1'b0;
            r_modeExt <= 1'b0;
        end else if (QST) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_qz      <= '1;
            r_qzVld   <= 1'b0;
        end else if (!QEN) begin
            r_qzVld   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_lastSrv <= w_nextLastSrv;
            r_qzVld   <= w_xfer;
            if (w_xfer) begin
                r_qz      <= EXT_ACK ? EXT_DAT : INT_DAT;
                r_modeExt <= EXT_ACK;
            end
        end
    end

endmodule
